cv32e40s_wb_trace_buffer: RTL and testbench

Captures instructions leaving the writeback stage into a small FIFO of trace records and drains them through a valid/ready port to a testbench or debug consumer. It sits directly downstream of the EX/WB pipeline register, beside the core logger, and sees the same `ex_wb_pipe_t` bundle. It also keeps retire, illegal-instruction and drop counters.

---
 rtl/cv32e40s_wb_trace_buffer_pkg.sv | 34 +++
 rtl/cv32e40s_wb_trace_buffer_if.sv | 30 +++
 rtl/cv32e40s_wb_trace_fifo.sv | 73 +++++++
 rtl/cv32e40s_wb_trace_buffer.sv | 127 ++++++++++++
 tb/tb_cv32e40s_wb_trace_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40s_wb_trace_buffer_pkg.sv
// Shared types and constants for the writeback trace buffer.
// The record layout gains a timestamp field when CV32E40S_TRACE_TIMESTAMP_EN is defined.
package cv32e40s_wb_trace_buffer_pkg;

    localparam int unsigned WB_TRACE_DEPTH_DEFAULT = 32'd4;
    localparam int unsigned WB_TRACE_SEQ_W         = 32'd16;

    typedef struct packed {
        logic        instr_valid;
        logic        illegal_insn;
        logic [31:0] pc;
    } ex_wb_pipe_t;

    typedef struct packed {
        logic [31:0]               pc;
        logic                      illegal;
        logic [WB_TRACE_SEQ_W-1:0] seq;
`ifdef CV32E40S_TRACE_TIMESTAMP_EN
        logic [31:0]               tstamp;
`endif
    } wb_trace_rec_t;

    // Drop counter sticks at all-ones instead of wrapping back to zero
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cv32e40s_wb_trace_buffer_if.sv
// Trace drain port: valid/ready handshake plus the head record fields.
// The buffer drives the master side, the consumer the slave side.
interface cv32e40s_wb_trace_buffer_if;

    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic        trace_illegal_o;
    logic [15:0] trace_seq_o;
    logic [31:0] trace_tstamp_o;

    modport master (
        output trace_valid_o,
        output trace_pc_o,
        output trace_illegal_o,
        output trace_seq_o,
        output trace_tstamp_o,
        input  trace_ready_i
    );

    modport slave (
        input  trace_valid_o,
        input  trace_pc_o,
        input  trace_illegal_o,
        input  trace_seq_o,
        input  trace_tstamp_o,
        output trace_ready_i
    );

endinterface

// File: rtl/cv32e40s_wb_trace_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; the record type is a parameter.
// Pushes into a full FIFO are ignored unless a pop happens in the same cycle.
module cv32e40s_wb_trace_fifo #(
    parameter int unsigned DEPTH = 32'd4,
    parameter type         T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_do_pop;
    logic        w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = pop_i & ~w_empty & ~clear_i;
    assign w_do_push = push_i & (~w_full | w_do_pop) & ~clear_i;

    // Read and write pointers; flush returns both to zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= {(AW+1){1'b0}};
            r_rptr <= {(AW+1){1'b0}};
        end else if (clear_i) begin
            r_wptr <= {(AW+1){1'b0}};
            r_rptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Record storage; entries are only observable while the FIFO is non-empty
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_i;
        end
    end

    // Head entry, forced to zero when nothing is queued
    always_comb begin
        data_o = '0;
        if (w_empty) begin
            data_o = '0;
        end else begin
            data_o = r_mem[r_rptr[AW-1:0]];
        end
    end

    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: rtl/cv32e40s_wb_trace_buffer.sv
// Writeback trace buffer: captures retiring (or only illegal) instructions into a FIFO
// and keeps retire/illegal/drop counters. CV32E40S_TRACE_TIMESTAMP_EN adds cycle stamps.
module cv32e40s_wb_trace_buffer
    import cv32e40s_wb_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = WB_TRACE_DEPTH_DEFAULT,
    parameter bit          CAPTURE_ALL = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  ex_wb_pipe_t                        ex_wb_pipe_i,
    input  logic                               wb_valid_i,
    input  logic                               clear_i,
    cv32e40s_wb_trace_buffer_if.master         trace_if,
    output logic [31:0]                        retire_cnt_o,
    output logic [31:0]                        illegal_cnt_o,
    output logic [15:0]                        drop_cnt_o,
    output logic                               overflow_o
);

    logic                      w_retire;
    logic                      w_capture;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_full;
    logic                      w_empty;
    wb_trace_rec_t             w_rec;
    wb_trace_rec_t             w_head;

    logic [WB_TRACE_SEQ_W-1:0] r_seq;
    logic [31:0]               r_retire_cnt;
    logic [31:0]               r_illegal_cnt;
    logic [15:0]               r_drop_cnt;
    logic                      r_overflow;

    assign w_retire  = wb_valid_i & ex_wb_pipe_i.instr_valid;
    assign w_capture = w_retire & (CAPTURE_ALL | ex_wb_pipe_i.illegal_insn);
    // Pop depends only on registered state and ready, so ready never reaches valid/data
    assign w_pop     = ~w_empty & trace_if.trace_ready_i;
    assign w_push    = w_capture & (~w_full | w_pop) & ~clear_i;
    assign w_drop    = w_capture & w_full & ~w_pop & ~clear_i;

`ifdef CV32E40S_TRACE_TIMESTAMP_EN
    logic [31:0] r_tstamp;

    // Free-running cycle counter, deliberately untouched by clear_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tstamp <= 32'd0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end
`endif

    // Assemble the record for the instruction currently in writeback
    always_comb begin
        w_rec         = '0;
        w_rec.pc      = ex_wb_pipe_i.pc;
        w_rec.illegal = ex_wb_pipe_i.illegal_insn;
        w_rec.seq     = r_seq;
`ifdef CV32E40S_TRACE_TIMESTAMP_EN
        w_rec.tstamp  = r_tstamp;
`endif
    end

    cv32e40s_wb_trace_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_trace_rec_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_push),
        .data_i  (w_rec),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Sequence number and event counters; clear wins over any same-cycle event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq         <= {WB_TRACE_SEQ_W{1'b0}};
            r_retire_cnt  <= 32'd0;
            r_illegal_cnt <= 32'd0;
            r_drop_cnt    <= 16'd0;
            r_overflow    <= 1'b0;
        end else if (clear_i) begin
            r_seq         <= {WB_TRACE_SEQ_W{1'b0}};
            r_retire_cnt  <= 32'd0;
            r_illegal_cnt <= 32'd0;
            r_drop_cnt    <= 16'd0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_retire) begin
                r_seq        <= r_seq + 16'd1;
                r_retire_cnt <= r_retire_cnt + 32'd1;
                if (ex_wb_pipe_i.illegal_insn) begin
                    r_illegal_cnt <= r_illegal_cnt + 32'd1;
                end
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_if.trace_valid_o   = ~w_empty;
    assign trace_if.trace_pc_o      = w_head.pc;
    assign trace_if.trace_illegal_o = w_head.illegal;
    assign trace_if.trace_seq_o     = w_head.seq;
`ifdef CV32E40S_TRACE_TIMESTAMP_EN
    assign trace_if.trace_tstamp_o  = w_head.tstamp;
`else
    assign trace_if.trace_tstamp_o  = 32'd0;
`endif

    assign retire_cnt_o  = r_retire_cnt;
    assign illegal_cnt_o = r_illegal_cnt;
    assign drop_cnt_o    = r_drop_cnt;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_cv32e40s_wb_trace_buffer.sv
// Self-checking bench: scoreboard queue of expected records plus a vector table
// and hand-written sequences for overflow, clear, wrap and reset corners.
module tb_cv32e40s_wb_trace_buffer;
    import cv32e40s_wb_trace_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_ni;
    ex_wb_pipe_t pipe;
    logic        wbv;
    logic        clr;
    logic [31:0] retire_cnt;
    logic [31:0] illegal_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    cv32e40s_wb_trace_buffer_if tif();

    cv32e40s_wb_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_ALL(1'b0)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .ex_wb_pipe_i  (pipe),
        .wb_valid_i    (wbv),
        .clear_i       (clr),
        .trace_if      (tif),
        .retire_cnt_o  (retire_cnt),
        .illegal_cnt_o (illegal_cnt),
        .drop_cnt_o    (drop_cnt),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ill;
        logic [15:0] seq;
        logic [31:0] ts;
    } rec_t;

    typedef struct {
        logic        wbv;
        logic        iv;
        logic        il;
        logic [31:0] pc;
        logic        rdy;
        logic        cl;
        logic        exp_valid;
        logic [15:0] exp_drop;
        logic        exp_ovf;
    } vec_t;

    rec_t        sb[$];
    vec_t        tbl[14];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_seq;
    logic [31:0] m_ret;
    logic [31:0] m_ill;
    logic [15:0] m_drop;
    logic        m_ovf;
    logic [31:0] tb_cyc;

    // Reference cycle count since reset release
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) tb_cyc <= 32'd0;
        else         tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ts();
`ifdef CV32E40S_TRACE_TIMESTAMP_EN
        return tb_cyc;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        sb.delete();
        m_seq  = 16'd0;
        m_ret  = 32'd0;
        m_ill  = 32'd0;
        m_drop = 16'd0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_head();
        rec_t r;
        chk("head_valid", {95'd0, tif.trace_valid_o}, {95'd0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            r = sb[0];
            chk("head_rec",
                {15'd0, tif.trace_pc_o, tif.trace_illegal_o, tif.trace_seq_o, tif.trace_tstamp_o},
                {15'd0, r.pc, r.ill, r.seq, r.ts});
        end
    endtask

    task automatic check_counters();
        chk("retire_cnt",  {64'd0, retire_cnt},  {64'd0, m_ret});
        chk("illegal_cnt", {64'd0, illegal_cnt}, {64'd0, m_ill});
        chk("drop_cnt",    {80'd0, drop_cnt},    {80'd0, m_drop});
        chk("overflow",    {95'd0, overflow},    {95'd0, m_ovf});
    endtask

    // One cycle: drive at negedge, check head, update model, advance, check counters
    task automatic step(input logic v, input logic iv, input logic il, input logic [31:0] pc,
                        input logic rdy, input logic cl);
        logic ret, cap, pop, full;
        rec_t r;
        wbv               = v;
        pipe.instr_valid  = iv;
        pipe.illegal_insn = il;
        pipe.pc           = pc;
        tif.trace_ready_i = rdy;
        clr               = cl;
        #1;
        check_head();
        ret  = v & iv;
        cap  = ret & il;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        if (cl) begin
            model_reset();
        end else begin
            if (cap) begin
                if (!full || pop) begin
                    r.pc = pc; r.ill = il; r.seq = m_seq; r.ts = exp_ts();
                    sb.push_back(r);
                end else begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    m_ovf = 1'b1;
                end
            end
            if (pop) void'(sb.pop_front());
            if (ret) begin
                m_seq = m_seq + 16'd1;
                m_ret = m_ret + 32'd1;
                if (il) m_ill = m_ill + 32'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_counters();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        // Overflow, full-with-pop and non-capturing patterns
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h20c, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h210, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h214, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h218, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h21c, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 16'd2, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1};

        rst_ni = 1'b0; wbv = 1'b0; clr = 1'b0; pipe = '0; tif.trace_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", {95'd0, tif.trace_valid_o}, 96'd0);
        chk("reset_cnts", {15'd0, retire_cnt, illegal_cnt, drop_cnt, overflow}, 96'd0);
        rst_ni = 1'b1;

        // Single capture, held while not ready
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        chk("single_fields", {47'd0, tif.trace_valid_o, tif.trace_pc_o, tif.trace_illegal_o, tif.trace_seq_o},
                             {47'd0, 1'b1, 32'h100, 1'b1, 16'd0});
        repeat (3) idle(1'b0);
        chk("single_hold", {63'd0, tif.trace_pc_o, tif.trace_illegal_o}, {63'd0, 32'h100, 1'b1});
        idle(1'b1);
        idle(1'b0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].wbv, tbl[i].iv, tbl[i].il, tbl[i].pc, tbl[i].rdy, tbl[i].cl);
            chk($sformatf("vec%0d_valid", i), {95'd0, tif.trace_valid_o}, {95'd0, tbl[i].exp_valid});
            chk($sformatf("vec%0d_drop", i), {80'd0, drop_cnt}, {80'd0, tbl[i].exp_drop});
            chk($sformatf("vec%0d_ovf", i), {95'd0, overflow}, {95'd0, tbl[i].exp_ovf});
        end

        // Clear beats a same-cycle capture and pop
        step(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h408, 1'b1, 1'b1);
        chk("clear_all", {15'd0, tif.trace_valid_o, retire_cnt, illegal_cnt, drop_cnt, overflow}, 96'd0);
        idle(1'b0);

        // Filtering and sequence wrap over 0x10005 retires
        for (int i = 0; i < 32'h10005; i++) begin
            step(1'b1, 1'b1, (i == 0) || (i == 32'h8000) || (i == 32'h10004),
                 32'h1000 + (32'(i) << 2), 1'b1, 1'b0);
        end
        chk("wrap_counts", {32'd0, retire_cnt, illegal_cnt}, {32'd0, 32'h10005, 32'd3});
        chk("wrap_seq", {79'd0, tif.trace_valid_o, tif.trace_seq_o}, {79'd0, 1'b1, 16'h0004});
        idle(1'b1);

        // Asynchronous reset while three records are queued
        step(1'b1, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h604, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h608, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("rst_trace", {14'd0, tif.trace_valid_o, tif.trace_pc_o, tif.trace_illegal_o, tif.trace_seq_o,
                          tif.trace_tstamp_o}, 96'd0);
        chk("rst_cnts", {15'd0, retire_cnt, illegal_cnt, drop_cnt, overflow}, 96'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) idle(1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
`ifdef CV32E40S_TRACE_TIMESTAMP_EN
        chk("rst_tstamp", {64'd0, tif.trace_tstamp_o}, {64'd0, 32'd3});
`else
        chk("rst_tstamp", {64'd0, tif.trace_tstamp_o}, 96'd0);
`endif
        idle(1'b1);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
